// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_ctrl
// Brief    : Round-robin shares one serial sequence detector between two
//            requesters; shifts each word MSB-first and returns {id, hit count}.
//            Optional macro SEQ_DETECT_CTRL_FIRST_POS_EN adds res_first_pos.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             det_clr,
    output logic             det_in,
    input  logic             det_out,
    output logic             res_valid,
    output logic             res_id,
    output logic [CNT_W-1:0] res_count,
`ifdef SEQ_DETECT_CTRL_FIRST_POS_EN
    output logic [CNT_W-1:0] res_first_pos,
`endif
    input  logic             res_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_data;
    logic             r_id;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_idx;
    logic             w_any;
    logic             w_grant;
    logic             w_accept;
    logic             w_sample;

    assign w_any    = req0_valid | req1_valid;
    // Contention goes to whoever did not win last time.
    assign w_grant  = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_accept = (r_state == S_IDLE) & w_any;
    // det_out lags det_in by one edge, so SHIFT k=0 has nothing to sample yet
    // and DRAIN collects the result of the final bit.
    assign w_sample = ((r_state == S_SHIFT) && (r_idx != '0)) || (r_state == S_DRAIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        det_clr    = 1'b0;
        det_in     = 1'b0;
        res_valid  = 1'b0;
        if (reset) begin
            det_clr = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    req0_ready = w_any & ~w_grant;
                    req1_ready = w_any & w_grant;
                    if (w_any) begin
                        w_next = S_CLR;
                    end
                end
                S_CLR: begin
                    det_clr = 1'b1;
                    w_next  = S_SHIFT;
                end
                S_SHIFT: begin
                    det_in = r_data[WIDTH-1];
                    if (r_idx == c_last_idx) begin
                        w_next = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    w_next = S_DONE;
                end
                S_DONE: begin
                    res_valid = 1'b1;
                    if (res_ready) begin
                        w_next = S_IDLE;
                    end
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_DETECT_CTRL_FIRST_POS_EN
    logic [CNT_W-1:0] r_first_pos;
    logic [CNT_W-1:0] w_samp_idx;

    assign w_samp_idx = (r_state == S_DRAIN) ? c_last_idx : (r_idx - c_one);

    // All-ones marks "no hit yet"; it never aliases a real bit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_first_pos <= '1;
        end else if (w_accept) begin
            r_first_pos <= '1;
        end else if (w_sample && det_out && (r_first_pos == '1)) begin
            r_first_pos <= w_samp_idx;
        end
    end

    assign res_first_pos = r_first_pos;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data       <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_count      <= '0;
            r_idx        <= '0;
        end else begin
            if (w_accept) begin
                r_data       <= w_grant ? req1_data : req0_data;
                r_id         <= w_grant;
                r_last_grant <= w_grant;
                r_count      <= '0;
            end
            if (r_state == S_CLR) begin
                r_idx <= '0;
            end
            if (r_state == S_SHIFT) begin
                r_data <= {r_data[WIDTH-2:0], 1'b0};
                r_idx  <= r_idx + c_one;
            end
            if (w_sample && det_out) begin
                r_count <= r_count + c_one;
            end
        end
    end

    assign res_id    = r_id;
    assign res_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_ctrl
// Brief    : Directed bench for seq_detect_ctrl with an "11" detector model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             det_clr;
    logic             det_in;
    logic             det_out;
    logic             res_valid;
    logic             res_id;
    logic [CNT_W-1:0] res_count;
`ifdef SEQ_DETECT_CTRL_FIRST_POS_EN
    logic [CNT_W-1:0] res_first_pos;
`endif
    logic             res_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .det_clr    (det_clr),
        .det_in     (det_in),
        .det_out    (det_out),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_count  (res_count),
`ifdef SEQ_DETECT_CTRL_FIRST_POS_EN
        .res_first_pos (res_first_pos),
`endif
        .res_ready  (res_ready)
    );

    // Detector: Moore output high when the last two consumed bits are 11.
    logic [1:0] det_hist;
    always @(posedge clk) begin
        if (det_clr) det_hist <= 2'b00;
        else         det_hist <= {det_hist[0], det_in};
    end
    assign det_out = (det_hist == 2'b11);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40 && res_valid !== 1'b1; i++) @(negedge clk);
        #1;
        chk(tag, res_valid, 1);
    endtask

    task automatic check_result(input string tag, input logic id, input int cnt, input int fp);
        chk({tag, "_id"}, res_id, id);
        chk({tag, "_count"}, res_count, cnt);
`ifdef SEQ_DETECT_CTRL_FIRST_POS_EN
        chk({tag, "_first_pos"}, res_first_pos, fp);
`endif
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk(tag, res_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        int         exp_id;

        // ---- 1: reset, single word F0, cycle-accurate serialisation ----
        reset = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 8'hF0;
        req1_valid = 1'b0; req1_data = 8'h00;
        @(negedge clk); #1;
        chk("rst_det_clr", det_clr, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_req0_ready", req0_ready, 0);
        @(negedge clk); #1;
        chk("rst_res_count", res_count, 0);
        chk("rst_res_id", res_id, 0);
`ifdef SEQ_DETECT_CTRL_FIRST_POS_EN
        chk("rst_first_pos", res_first_pos, 15);
`endif
        reset = 1'b0; #1;
        chk("t1_req0_ready", req0_ready, 1);
        chk("t1_req1_ready", req1_ready, 0);
        @(negedge clk); req0_valid = 1'b0; #1;
        chk("t1_clr", det_clr, 1);
        chk("t1_ready_low", req0_ready, 0);
        pat = 8'hF0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            chk("t1_det_in", det_in, pat[7-k]);
            chk("t1_shift_clr", det_clr, 0);
        end
        @(negedge clk); #1;
        chk("t1_drain_in", det_in, 0);
        chk("t1_drain_valid", res_valid, 0);
        @(negedge clk); #1;
        chk("t1_latency", res_valid, 1);
        check_result("t1", 1'b0, 3, 1);
        handshake("t1_hs");

        // ---- 2: both valid after reset -> req0 first, then req1 ----
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        req0_valid = 1'b1; req0_data = 8'hFF;
        req1_valid = 1'b1; req1_data = 8'hAA;
        #1;
        chk("t2_req0_ready", req0_ready, 1);
        chk("t2_req1_ready", req1_ready, 0);
        @(negedge clk); req0_valid = 1'b0; #1;
        chk("t2_busy", req1_ready, 0);
        wait_valid("t2a_valid");
        check_result("t2a", 1'b0, 7, 1);
        handshake("t2a_hs");
        chk("t2_req1_turn", req1_ready, 1);
        @(negedge clk); req1_valid = 1'b0;
        wait_valid("t2b_valid");
        check_result("t2b", 1'b1, 0, 15);
        handshake("t2b_hs");

        // ---- 3: continuous contention alternates 0,1,0,1 ----
        req0_valid = 1'b1; req0_data = 8'h0F;
        req1_valid = 1'b1; req1_data = 8'h33;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_id = i % 2;
            chk("t3_req0_ready", req0_ready, (exp_id == 0));
            chk("t3_req1_ready", req1_ready, (exp_id == 1));
            @(negedge clk);
            wait_valid("t3_valid");
            if (exp_id == 0) check_result("t3_w0", 1'b0, 3, 5);
            else             check_result("t3_w1", 1'b1, 2, 3);
            handshake("t3_hs");
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // ---- 4: stalled result stays stable, no grant meanwhile ----
        req0_valid = 1'b1; req0_data = 8'hC0;
        req1_valid = 1'b1; req1_data = 8'h03;
        #1;
        chk("t4_req0_ready", req0_ready, 1);
        @(negedge clk); req0_valid = 1'b0;
        wait_valid("t4_valid");
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", res_valid, 1);
            chk("t4_hold_id", res_id, 0);
            chk("t4_hold_count", res_count, 1);
            chk("t4_no_ready", req1_ready, 0);
            @(negedge clk); #1;
        end
        res_ready = 1'b1;
        @(negedge clk); res_ready = 1'b0; #1;
        chk("t4_released", res_valid, 0);
        chk("t4_req1_ready", req1_ready, 1);

        // ---- 5: reset during SHIFT k=3 aborts the word ----
        @(negedge clk); #1;
        chk("t5_clr", det_clr, 1);
        for (int k = 0; k < 4; k++) @(negedge clk);
        #1;
        chk("t5_k3_clr", det_clr, 0);
        reset = 1'b1; #1;
        chk("t5_rst_clr", det_clr, 1);
        chk("t5_rst_in", det_in, 0);
        chk("t5_rst_ready", req1_ready, 0);
        @(negedge clk); reset = 1'b0; #1;
        chk("t5_idle_valid", res_valid, 0);
        chk("t5_idle_clr", det_clr, 0);
        chk("t5_req1_ready", req1_ready, 1);
        @(negedge clk); req1_valid = 1'b0;
        wait_valid("t5_valid");
        check_result("t5", 1'b1, 1, 7);
        handshake("t5_hs");

        // ---- 6: back-to-back accept in the IDLE cycle after DONE ----
        req0_valid = 1'b1; req0_data = 8'h0F; #1;
        chk("t6_ready", req0_ready, 1);
        @(negedge clk); req0_valid = 1'b0;
        wait_valid("t6a_valid");
        check_result("t6a", 1'b0, 3, 5);
        res_ready = 1'b1; req0_valid = 1'b1; req0_data = 8'hF0; #1;
        chk("t6_done_ready", req0_ready, 0);
        @(negedge clk); res_ready = 1'b0; #1;
        chk("t6_idle_valid", res_valid, 0);
        chk("t6_idle_ready", req0_ready, 1);
        @(negedge clk); req0_valid = 1'b0; #1;
        chk("t6_clr", det_clr, 1);
        wait_valid("t6b_valid");
        check_result("t6b", 1'b0, 3, 1);
        handshake("t6b_hs");
        @(negedge clk); #1;
        chk("t6_no_dup", res_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
